// File: rtl/tans_bit_packer_if.sv
// Beat-in / byte-out bus between HF_tANS_recoder, tans_bit_packer and the byte consumer.
interface tans_bit_packer_if #(
  parameter int SYM_W   = 3,
  parameter int STATE_W = 4,
  parameter int OUT_W   = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         BTR;
  logic [SYM_W-1:0]   o_stream;
  logic               flush;
  logic [STATE_W-1:0] final_state;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_data;
  logic               out_last;
  logic [2:0]         pad_bits;
  logic               busy;

  // Upstream recoder plus downstream consumer.
  modport master (
    output in_valid, BTR, o_stream, flush, final_state, out_ready,
    input  in_ready, out_valid, out_data, out_last, pad_bits, busy
  );

  // The packer itself.
  modport slave (
    input  in_valid, BTR, o_stream, flush, final_state, out_ready,
    output in_ready, out_valid, out_data, out_last, pad_bits, busy
  );
endinterface

// File: rtl/tans_bit_packer.sv
// Packs variable-length tANS recoder output plus the final state MSB-first into
// bytes, framing each stream with zero padding and a last-byte marker.
module tans_bit_packer #(
  parameter int SYM_W   = 3,
  parameter int STATE_W = 4,
  parameter int ACC_W   = 16,
  parameter int OUT_W   = 8
) (
  input logic              PHI,
  input logic              RST,
  tans_bit_packer_if.slave bus
);
  localparam int CNT_W = $clog2(ACC_W + 1);

  typedef enum logic [1:0] {RUN, FSTATE, DRAIN} state_t;

  state_t             state, state_next;
  logic [ACC_W-1:0]   acc, acc_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [STATE_W-1:0] fs_q, fs_next;
  logic               ov_q, ov_next;
  logic [OUT_W-1:0]   od_q, od_next;
  logic               ol_q, ol_next;
  logic [2:0]         op_q, op_next;

  logic               in_ready_int;
  logic               accept;
  logic               avail;
  logic               load;
  logic [CNT_W-1:0]   take;
  logic [CNT_W-1:0]   shift_n;
  logic [ACC_W-1:0]   ins;
  logic [SYM_W-1:0]   mask;

  assign in_ready_int = (state == RUN) && (cnt <= CNT_W'(ACC_W - SYM_W)) && !RST;
  assign accept       = bus.in_valid && in_ready_int;
  assign mask         = ~({SYM_W{1'b1}} << bus.BTR);

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign bus.out_last  = ol_q;
  assign bus.pad_bits  = op_q;
  assign bus.busy      = (state != RUN);

  always_comb begin
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    fs_next    = fs_q;
    ov_next    = ov_q;
    od_next    = od_q;
    ol_next    = ol_q;
    op_next    = op_q;
    take       = '0;
    shift_n    = '0;
    ins        = '0;

    avail = (cnt >= CNT_W'(OUT_W)) || ((state == DRAIN) && (cnt != '0));
    load  = (!ov_q || bus.out_ready) && avail;

    // Drain removes the oldest bits (top of the valid window); the append below
    // shifts new bits in at the bottom, so both can happen in the same cycle.
    if (load) begin
      ov_next = 1'b1;
      if (cnt >= CNT_W'(OUT_W)) begin
        od_next = OUT_W'(acc >> (cnt - CNT_W'(OUT_W)));
        take    = CNT_W'(OUT_W);
        op_next = '0;
        ol_next = (state == DRAIN) && (cnt == CNT_W'(OUT_W));
      end else begin
        od_next = OUT_W'(acc << (CNT_W'(OUT_W) - cnt));
        take    = cnt;
        op_next = 3'(CNT_W'(OUT_W) - cnt);
        ol_next = 1'b1;
      end
    end else if (bus.out_ready) begin
      ov_next = 1'b0;
    end

    unique case (state)
      RUN: begin
        if (accept) begin
          shift_n = CNT_W'(bus.BTR);
          ins     = ACC_W'(bus.o_stream & mask);
        end
        if (bus.flush) begin
          fs_next    = bus.final_state;
          state_next = FSTATE;
        end
      end
      FSTATE: begin
        if (cnt <= CNT_W'(ACC_W - STATE_W)) begin
          shift_n    = CNT_W'(STATE_W);
          ins        = ACC_W'(fs_q);
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (ov_q && bus.out_ready && ol_q) state_next = RUN;
      end
      default: state_next = RUN;
    endcase

    acc_next = (acc << shift_n) | ins;
    cnt_next = cnt - take + shift_n;
  end

  always_ff @(posedge PHI) begin
    if (RST) begin
      state <= RUN;
      acc   <= '0;
      cnt   <= '0;
      fs_q  <= '0;
      ov_q  <= 1'b0;
      od_q  <= '0;
      ol_q  <= 1'b0;
      op_q  <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      cnt   <= cnt_next;
      fs_q  <= fs_next;
      ov_q  <= ov_next;
      od_q  <= od_next;
      ol_q  <= ol_next;
      op_q  <= op_next;
    end
  end
endmodule

// File: tb/tb_tans_bit_packer.sv
// Directed bench for tans_bit_packer with hand-computed bytes and framing.
module tb_tans_bit_packer;
  logic PHI;
  logic RST;
  int   vectors;
  int   miscompares;

  tans_bit_packer_if #(.SYM_W(3), .STATE_W(4), .OUT_W(8)) bus ();

  tans_bit_packer #(.SYM_W(3), .STATE_W(4), .ACC_W(16), .OUT_W(8)) dut (
    .PHI (PHI),
    .RST (RST),
    .bus (bus)
  );

  initial PHI = 1'b0;
  always #5 PHI = ~PHI;

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge PHI);
    #1;
  endtask

  task automatic beat(input logic [1:0] n, input logic [2:0] b);
    bus.in_valid = 1'b1;
    bus.BTR      = n;
    bus.o_stream = b;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int i;
    for (i = 0; i < 12 && !bus.out_valid; i++) tick();
    vectors++;
    if (bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_wait got=%b exp=1", name, bus.out_valid);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.in_valid = 1'b0; bus.BTR = '0; bus.o_stream = '0;
    bus.flush = 1'b0; bus.final_state = '0; bus.out_ready = 1'b1;
    tick(); tick();
    vectors++;
    if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
    vectors++;
    if ({bus.out_valid, bus.out_data, bus.out_last, bus.pad_bits, bus.busy} !== 14'd0) begin
      miscompares++;
      $display("FAIL rst_outputs got=%b/%h/%b/%0d/%b exp=0", bus.out_valid, bus.out_data, bus.out_last, bus.pad_bits, bus.busy);
    end
    RST = 1'b0;
    tick();
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_rst got=in_ready %b out_valid %b exp=1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_single_byte();
    bus.out_ready = 1'b1;
    beat(2'd3, 3'b101);
    beat(2'd3, 3'b110);
    beat(2'd2, 3'b001);
    vectors++;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL byte_latency got=%b exp=0", bus.out_valid); end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hB9 || bus.out_last !== 1'b0) begin
      miscompares++;
      $display("FAIL byte_b9 got=%b/%h/%b exp=1/b9/0", bus.out_valid, bus.out_data, bus.out_last);
    end
    vectors++;
    if (dut.cnt !== 5'd0) begin miscompares++; $display("FAIL byte_cnt got=%0d exp=0", dut.cnt); end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL byte_consumed got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_btr_zero();
    beat(2'd1, 3'b111);
    beat(2'd0, 3'b111);
    beat(2'd3, 3'b010);
    beat(2'd3, 3'b110);
    beat(2'd1, 3'b001);
    tick();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hAD) begin
      miscompares++;
      $display("FAIL btr_zero got=%b/%h exp=1/ad", bus.out_valid, bus.out_data);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int accepts = 0;
    int bytes = 0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.BTR       = 2'd3;
    bus.o_stream  = 3'b111;
    for (int i = 0; i < 12; i++) begin
      if (bus.in_ready) accepts++;
      if (bus.out_valid) begin
        vectors++;
        if (bus.out_data !== 8'hFF || bus.out_last !== 1'b0) begin
          miscompares++;
          $display("FAIL held_byte got=%h/%b exp=ff/0", bus.out_data, bus.out_last);
        end
      end
      tick();
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (accepts != 8) begin miscompares++; $display("FAIL bp_accepts got=%0d exp=8", accepts); end
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_full got=in_ready %b out_valid %b exp=0 1", bus.in_ready, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) begin
        bytes++;
        vectors++;
        if (bus.out_data !== 8'hFF) begin miscompares++; $display("FAIL bp_byte got=%h exp=ff", bus.out_data); end
      end
      tick();
    end
    vectors++;
    if (bytes * 8 != accepts * 3 || bytes != 3) begin
      miscompares++;
      $display("FAIL bp_bits got=%0d bits out exp=%0d", bytes * 8, 24);
    end
    vectors++;
    if (dut.cnt !== 5'd0) begin miscompares++; $display("FAIL bp_cnt got=%0d exp=0", dut.cnt); end
  endtask

  task automatic start_padded_stream();
    bus.out_ready = 1'b0;
    beat(2'd3, 3'b101);
    bus.flush = 1'b1;
    bus.final_state = 4'b1010;
    tick();
    bus.flush = 1'b0;
    bus.final_state = 4'b0000;
  endtask

  task automatic test_flush_padded();
    start_padded_stream();
    vectors++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fstate_busy got=busy %b in_ready %b exp=1 0", bus.busy, bus.in_ready);
    end
    wait_valid("pad");
    vectors++;
    if (bus.out_data !== 8'hB4 || bus.out_last !== 1'b1 || bus.pad_bits !== 3'd1 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL pad_byte got=%h/%b/%0d/%b exp=b4/1/1/1", bus.out_data, bus.out_last, bus.pad_bits, bus.busy);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hB4 || bus.pad_bits !== 3'd1) begin
      miscompares++;
      $display("FAIL pad_stable got=%b/%h/%0d exp=1/b4/1", bus.out_valid, bus.out_data, bus.pad_bits);
    end
    bus.out_ready = 1'b1;
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL pad_done got=%b/%b/%b exp=0/0/1", bus.out_valid, bus.busy, bus.in_ready);
    end
  endtask

  task automatic test_flush_exact();
    for (int pass = 0; pass < 2; pass++) begin
      bus.out_ready = 1'b1;
      beat(2'd2, 3'b011);
      bus.final_state = 4'b0110;
      if (pass == 1) bus.flush = 1'b1;
      beat(2'd2, 3'b000);
      bus.flush = 1'b1;
      if (pass == 1) bus.flush = 1'b0;
      if (pass == 0) begin
        tick();
        bus.flush = 1'b0;
      end
      wait_valid("exact");
      vectors++;
      if (bus.out_data !== 8'hC6 || bus.out_last !== 1'b1 || bus.pad_bits !== 3'd0) begin
        miscompares++;
        $display("FAIL exact_byte pass %0d got=%h/%b/%0d exp=c6/1/0", pass, bus.out_data, bus.out_last, bus.pad_bits);
      end
      tick();
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL exact_done pass %0d got=%b/%b exp=0/0", pass, bus.out_valid, bus.busy);
      end
    end
  endtask

  task automatic test_reset_in_drain();
    start_padded_stream();
    wait_valid("rst_drain");
    RST = 1'b1;
    tick();
    RST = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || dut.cnt !== 5'd0) begin
      miscompares++;
      $display("FAIL drain_rst got=%b/%b/%0d exp=0/0/0", bus.out_valid, bus.busy, dut.cnt);
    end
    bus.out_ready = 1'b1;
    beat(2'd3, 3'b101);
    beat(2'd3, 3'b110);
    beat(2'd2, 3'b001);
    tick();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hB9 || bus.out_last !== 1'b0) begin
      miscompares++;
      $display("FAIL after_rst got=%b/%h/%b exp=1/b9/0", bus.out_valid, bus.out_data, bus.out_last);
    end
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single_byte();
    test_btr_zero();
    test_backpressure();
    test_flush_padded();
    test_flush_exact();
    test_reset_in_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/tans_bit_packer.md
Name: tans_bit_packer

Overview:
- Sits directly downstream of HF_tANS_recoder and consumes its per-cycle variable-length output (BTR bit count plus o_stream bits).
- At end of stream it appends the recoder's final_state.
- It packs the resulting bit stream MSB-first into bytes behind a valid/ready output handshake, for file or memory write-out.
- Padding and a last-byte marker frame each compressed stream.

Parameters:
SYM_W, 3, width of o_stream; max bits per input beat
STATE_W, 4, width of final_state
ACC_W, 16, bit accumulator depth; must be >= OUT_W + SYM_W + STATE_W - 1
OUT_W, 8, output word width

Ports:
PHI  input  1  clock, all logic on rising edge
RST  input  1  synchronous active-high reset
in_valid  input  1  BTR/o_stream beat valid
in_ready  output  1  packer can accept a beat this cycle
BTR  input  2  number of valid bits in o_stream (0..3)
o_stream  input  SYM_W  bits in o_stream[BTR-1:0]; bit BTR-1 is sent first
flush  input  1  end-of-stream pulse; final_state sampled same cycle
final_state  input  STATE_W  recoder end state, appended MSB-first
out_valid  output  1  out_data holds a byte
out_ready  input  1  consumer takes byte when out_valid && out_ready
out_data  output  OUT_W  packed byte; first bit in MSB
out_last  output  1  qualifies final byte of stream
pad_bits  output  3  count of zero pad bits in out_data LSBs; nonzero only with out_last
busy  output  1  high in FSTATE or DRAIN

Behaviour:
- Reset (RST high at edge): acc=0, cnt=0, state=RUN, out_valid=0, out_data=0, out_last=0, pad_bits=0, busy=0. in_ready forced 0 while RST high; 1 in the first cycle after release. Reset mid-operation discards all buffered bits and any held output byte.
- acc holds cnt bits (0..ACC_W); the oldest bit is at position cnt-1.
- in_ready = (state==RUN) && (cnt <= ACC_W-SYM_W) && !RST; this is combinational from registers.
- Beat accepted when in_valid && in_ready: acc = (acc<<BTR) | o_stream[BTR-1:0]; cnt += BTR.
  - BTR==0 is legal; no bits are added.
  - BTR==3 is legal.
- Output register loads when (!out_valid || out_ready) and a byte is available.
  - A byte is available when cnt>=8, or in DRAIN when cnt>0.
  - Loaded byte = acc[cnt-1 -: 8], the oldest bits.
  - Padded case: acc[cnt-1:0] followed by (8-cnt) zeros.
  - Load latency: out_valid rises on the edge after the edge on which cnt reaches >=8.
- Simultaneous load and accept in one cycle: the drain takes the old bits and the append adds new bits. cnt_next = cnt - taken + BTR.
- out_data, out_last and pad_bits are stable while out_valid && !out_ready.
- FSM:
  - RUN: flush=1 -> FSTATE, with final_state latched. If in_valid && in_ready in the same cycle, that beat is appended first.
  - FSTATE: when cnt <= ACC_W-STATE_W, append 4 state bits MSB-first and go to DRAIN; otherwise wait while bytes drain. No input is accepted.
  - DRAIN: emit bytes.
    - cnt>8: normal byte.
    - cnt==8: byte with out_last=1, pad_bits=0.
    - 1<=cnt<=7: padded byte with out_last=1, pad_bits=8-cnt.
    - When the last byte is handshaken -> RUN with cnt=0.
  - cnt is always >=4 on entry to DRAIN, so a DRAIN never emits nothing.
- flush outside RUN is ignored.
- in_valid while in_ready=0 is not consumed; the source holds the beat.
- No bit is ever lost or duplicated under any out_ready pattern.

Test Plan:
- Reset then idle -> all outputs 0 during RST; in_ready=1 and out_valid=0 one cycle after release.
- Beats (3,101),(3,110),(2,01) on consecutive cycles, out_ready=1 -> single byte 0xB9, out_valid one cycle after third beat, out_last=0, cnt returns 0.
- out_ready=0, continuous (3,111) beats -> first byte 0xFF held stable; in_ready drops once cnt>13; release out_ready -> all 0xFF bytes delivered, total bits out equal bits in.
- Beat (3,101) then flush with final_state=4'b1010 -> one byte 0xB4, out_last=1, pad_bits=1, busy high until handshake, then in_ready=1.
- Beats (2,11),(2,00) then flush with final_state=4'b0110; repeat with flush asserted on the same cycle as the second beat -> both give 0xC6, out_last=1, pad_bits=0.
- RST pulsed while in DRAIN with out_valid=1 and out_ready=0 -> next cycle out_valid=0, busy=0, cnt=0; a new stream packs correctly afterwards.
